// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage with a circular prefetch queue feeding decode.
// Each entry holds a fetched word and its PC+step. A decode-stage redirect flushes the queue.
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(1)
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_gnt,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       stall_d,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       instr_valid,
    output logic [XLEN-1:0]            instr_out,
    output logic [XLEN-1:0]            pc_plus_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [XLEN-1:0]  pcp_q   [DEPTH];

    logic             full;
    logic             pop;
    logic             push;
    logic [XLEN-1:0]  pc_next;

    // Request/handshake decode; the request is gated by reset so nothing is issued while held.
    always_comb begin
        full        = (count_q == CNT_W'(DEPTH));
        instr_valid = (count_q != '0);
        pop         = instr_valid & ~stall_d;
        imem_req    = reset & ~redirect_valid & (~full | pop);
        push        = imem_req & imem_gnt;
        pc_next     = fetch_pc_q + PC_STEP;
        imem_addr   = fetch_pc_q;
        count       = count_q;
        instr_out   = instr_valid ? instr_q[rd_ptr_q] : '0;
        pc_plus_out = instr_valid ? pcp_q[rd_ptr_q]   : '0;
    end

    // Next-state: a redirect overrides any push/pop bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = pc_next;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are only visible through the valid-gated head outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= '0;
                pcp_q[i]   <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= imem_rdata;
            pcp_q[wr_ptr_q]   <= pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: table of per-cycle vectors plus hand sequences
// for async reset and PC wrap. Instruction memory returns addr ^ 0xC0DE0000.
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_plus_out;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        gnt;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pcp;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    fetch_prefetch_unit #(
        .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'h1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rdata     (imem_rdata),
        .stall_d        (stall_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .pc_plus_out    (pc_plus_out),
        .count          (count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic g, input logic s, input logic r, input logic [31:0] rpc,
                       input logic rq, input logic [31:0] a, input logic v,
                       input logic [31:0] p, input logic [2:0] c);
        vec_t t;
        t.gnt = g; t.stall = s; t.redir = r; t.rpc = rpc;
        t.req = rq; t.addr = a; t.valid = v; t.pcp = p; t.cnt = c;
        vecs.push_back(t);
    endtask

    task automatic chk_all(input string tag, input logic rq, input logic [31:0] a,
                           input logic v, input logic [31:0] p, input logic [2:0] c);
        chk({tag, " imem_req"},    32'(imem_req),    32'(rq));
        chk({tag, " imem_addr"},   imem_addr,        a);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(v));
        chk({tag, " pc_plus_out"}, pc_plus_out,      p);
        chk({tag, " count"},       32'(count),       32'(c));
        chk({tag, " instr_out"},   instr_out,        v ? mem_word(p - 32'h1) : 32'h0);
    endtask

    initial begin
        reset          = 1'b0;
        imem_gnt       = 1'b0;
        stall_d        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        //         gnt   stall redir rpc       | req   addr      valid pcp       cnt
        add(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   3'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h1,   1'b1, 32'h1,   3'd1);
        add(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h2,   1'b1, 32'h1,   3'd2);
        add(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h3,   1'b1, 32'h1,   3'd3);
        add(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h4,   1'b1, 32'h1,   3'd4);
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h1,   3'd4);
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h5,   1'b1, 32'h2,   3'd4);
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h6,   1'b1, 32'h3,   3'd4);
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h7,   1'b1, 32'h4,   3'd4);
        add(1'b1, 1'b0, 1'b1, 32'h40,  1'b0, 32'h8,   1'b1, 32'h5,   3'd4);
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h0,   3'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h41,  1'b1, 32'h41,  3'd1);
        add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h41,  1'b0, 32'h0,   3'd0);
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h41,  1'b0, 32'h0,   3'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h42,  1'b1, 32'h42,  3'd1);
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h42,  1'b0, 32'h0,   3'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h43,  1'b1, 32'h43,  3'd1);
        add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h43,  1'b0, 32'h0,   3'd0);
        add(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h43,  1'b0, 32'h0,   3'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   3'd0);
        add(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h101, 1'b1, 32'h101, 3'd1);
        add(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h102, 1'b1, 32'h101, 3'd2);
        add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   3'd0);

        #2;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        @(posedge clk); #1;
        chk_all("reset_edge", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            imem_gnt       = vecs[i].gnt;
            stall_d        = vecs[i].stall;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                    vecs[i].valid, vecs[i].pcp, vecs[i].cnt);
            @(posedge clk); #1;
        end

        // Fill three entries, then assert reset mid-cycle.
        imem_gnt = 1'b1; stall_d = 1'b1; redirect_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("fill3 count", 32'(count), 32'd3);
        chk("fill3 addr", imem_addr, 32'h203);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        @(posedge clk); #1;
        chk_all("reset_hold", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        reset = 1'b1;
        #1;
        chk_all("restart", 1'b1, 32'h0, 1'b0, 32'h0, 3'd0);
        @(posedge clk); #1;
        chk_all("restart_head", 1'b1, 32'h1, 1'b1, 32'h1, 3'd1);

        // Redirect to the top of the address space and push across the wrap.
        imem_gnt = 1'b0; stall_d = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        redirect_valid = 1'b0; imem_gnt = 1'b1; stall_d = 1'b1;
        #1;
        chk_all("wrap_req", 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 3'd0);
        @(posedge clk); #1;
        imem_gnt = 1'b0;
        #1;
        chk("wrap pc_plus_out", pc_plus_out, 32'h0);
        chk("wrap instr_out", instr_out, mem_word(32'hFFFF_FFFF));
        chk("wrap imem_addr", imem_addr, 32'h0);
        chk("wrap count", 32'(count), 32'd1);
        chk("wrap instr_valid", 32'(instr_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
